// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES-128 stream front/back end.
// perm_idx maps a stream byte position to its FIPS linear byte index.
package aes_stream_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = AES_BLOCK_W / 8;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } core_state_e;

    // Order 1: stream byte k is state row k/4, column k%4, i.e. FIPS byte 4c+r.
    function automatic int perm_idx(input int order, input int k);
        if (order == 1) begin
            return 4 * (k % 4) + k / 4;
        end
        return k;
    endfunction

endpackage

// File: rtl/aes_byte_permute.sv
// Combinational 128-bit byte reorder between stream order and FIPS linear order.
// Byte 0 of either layout sits in the MSBs.
module aes_byte_permute
    import aes_stream_pkg::*;
#(
    parameter int ORDER   = 1,
    parameter bit TO_FIPS = 1'b1
) (
    input  logic [AES_BLOCK_W-1:0] din,
    output logic [AES_BLOCK_W-1:0] dout
);

    for (genvar k = 0; k < AES_BYTES; k++) begin : g_byte
        localparam int F = perm_idx(ORDER, k);
        if (TO_FIPS) begin : g_to_fips
            assign dout[AES_BLOCK_W-1-8*F -: 8] = din[AES_BLOCK_W-1-8*k -: 8];
        end else begin : g_to_stream
            assign dout[AES_BLOCK_W-1-8*k -: 8] = din[AES_BLOCK_W-1-8*F -: 8];
        end
    end

endmodule

// File: rtl/aes_block_stream_if.sv
// Stream front/back end for the AES-128 core: assembles input beats into a held
// block, launches the core, and serialises the captured result as output beats.
module aes_block_stream_if
    import aes_stream_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IN_ORDER  = 1,
    parameter int OUT_ORDER = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   core_start,
    output logic [AES_BLOCK_W-1:0] core_block,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] core_result,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   err_spurious
);

    localparam int BEATS = AES_BLOCK_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64 && DATA_W != 128) begin : g_bad_data_w
        $error("aes_block_stream_if: DATA_W must be 8, 16, 32, 64 or 128");
    end

    logic [AES_BLOCK_W-1:0] in_buf_q, in_buf_d, hold_q, hold_d, out_q, out_d;
    logic [CNT_W-1:0]       in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                   in_full_q, in_full_d, out_full_q, out_full_d, err_q, err_d;
    core_state_e            state_q, state_d;
    logic [AES_BLOCK_W-1:0] asm_block, fips_block, res_stream;
    logic                   s_fire, m_fire, launch, in_last;
    int                     in_shift, out_shift;

    aes_byte_permute #(.ORDER(IN_ORDER), .TO_FIPS(1'b1)) u_in_perm (
        .din  (asm_block),
        .dout (fips_block)
    );

    aes_byte_permute #(.ORDER(OUT_ORDER), .TO_FIPS(1'b0)) u_out_perm (
        .din  (core_result),
        .dout (res_stream)
    );

    // Valid/ready: a beat transfers on a rising edge where valid && ready; the source
    // holds valid and data until then. s_ready reopens in the cycle the held block launches.
    assign launch       = (state_q == C_IDLE) && in_full_q && !out_full_q;
    assign s_ready      = !in_full_q || launch;
    assign s_fire       = s_valid && s_ready;
    assign in_last      = (in_cnt_q == LAST_BEAT);
    assign m_valid      = out_full_q;
    assign m_fire       = out_full_q && m_ready;
    assign m_last       = out_full_q && (out_cnt_q == LAST_BEAT);
    assign core_block   = hold_q;
    assign err_spurious = err_q;
    assign busy         = (state_q == C_RUN) || in_full_q || out_full_q || (in_cnt_q != '0);

    always_comb begin
        in_shift  = (BEATS - 1 - int'(in_cnt_q)) * DATA_W;
        out_shift = (BEATS - 1 - int'(out_cnt_q)) * DATA_W;
        asm_block = in_buf_q | (AES_BLOCK_W'(s_data) << in_shift);
        m_data    = DATA_W'(out_q >> out_shift);
    end

    // The collector buffer is cleared on completion so the OR-merge above stays valid.
    always_comb begin
        in_buf_d  = in_buf_q;
        in_cnt_d  = in_cnt_q;
        hold_d    = hold_q;
        in_full_d = in_full_q;
        if (launch) begin
            in_full_d = 1'b0;
        end
        if (s_fire) begin
            if (in_last) begin
                in_buf_d  = '0;
                in_cnt_d  = '0;
                hold_d    = fips_block;
                in_full_d = 1'b1;
            end else begin
                in_buf_d = asm_block;
                in_cnt_d = in_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        err_d      = err_q;
        case (state_q)
            C_IDLE: begin
                if (core_done) begin
                    err_d = 1'b1;
                end
                if (launch) begin
                    core_start = 1'b1;
                    state_d    = C_RUN;
                end
            end
            C_RUN: begin
                if (core_done) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        out_d      = out_q;
        out_cnt_d  = out_cnt_q;
        out_full_d = out_full_q;
        if ((state_q == C_RUN) && core_done) begin
            out_d      = res_stream;
            out_cnt_d  = '0;
            out_full_d = 1'b1;
        end
        if (m_fire) begin
            if (out_cnt_q == LAST_BEAT) begin
                out_cnt_d  = '0;
                out_full_d = 1'b0;
            end else begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf_q   <= '0;
            in_cnt_q   <= '0;
            hold_q     <= '0;
            in_full_q  <= 1'b0;
            state_q    <= C_IDLE;
            err_q      <= 1'b0;
            out_q      <= '0;
            out_cnt_q  <= '0;
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_cnt_q   <= in_cnt_d;
            hold_q     <= hold_d;
            in_full_q  <= in_full_d;
            state_q    <= state_d;
            err_q      <= err_d;
            out_q      <= out_d;
            out_cnt_q  <= out_cnt_d;
            out_full_q <= out_full_d;
        end
    end

endmodule

// File: tb/tb_aes_block_stream_if.sv
// Directed bench for aes_block_stream_if: an 8-bit row-major instance and a
// 32-bit linear-order instance, each driven against a stub core.
`timescale 1ns/1ps
module tb_aes_block_stream_if;

    localparam logic [127:0] BLK1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RES1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] MASK = BLK1 ^ RES1;

    logic [7:0]  in8   [16] = '{8'h32, 8'h88, 8'h31, 8'he0, 8'h43, 8'h5a, 8'h31, 8'h37,
                                8'hf6, 8'h30, 8'h98, 8'h07, 8'ha8, 8'h8d, 8'ha2, 8'h34};
    logic [7:0]  out8  [16] = '{8'h39, 8'h02, 8'hdc, 8'h19, 8'h25, 8'hdc, 8'h11, 8'h6a,
                                8'h84, 8'h09, 8'h85, 8'h0b, 8'h1d, 8'hfb, 8'h97, 8'h32};
    logic [31:0] in32  [4]  = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
    logic [31:0] out32 [4]  = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};

    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT 8-bit, row-major ----------------
    logic         s_valid8 = 1'b0, s_ready8, core_start8, core_done8, inj8 = 1'b0;
    logic [7:0]   s_data8 = '0, m_data8;
    logic [127:0] core_block8, core_result8;
    logic         m_valid8, m_ready8 = 1'b0, m_last8, busy8, err8;

    aes_block_stream_if #(.DATA_W(8), .IN_ORDER(1), .OUT_ORDER(1)) u_dut8 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
        .core_start(core_start8), .core_block(core_block8),
        .core_done(core_done8), .core_result(core_result8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .m_last(m_last8),
        .busy(busy8), .err_spurious(err8)
    );

    // ---------------- DUT 32-bit, linear order ----------------
    logic         s_valid32 = 1'b0, s_ready32, core_start32, core_done32;
    logic [31:0]  s_data32 = '0, m_data32;
    logic [127:0] core_block32, core_result32;
    logic         m_valid32, m_ready32 = 1'b0, m_last32, busy32, err32;

    aes_block_stream_if #(.DATA_W(32), .IN_ORDER(0), .OUT_ORDER(0)) u_dut32 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid32), .s_ready(s_ready32), .s_data(s_data32),
        .core_start(core_start32), .core_block(core_block32),
        .core_done(core_done32), .core_result(core_result32),
        .m_valid(m_valid32), .m_ready(m_ready32), .m_data(m_data32), .m_last(m_last32),
        .busy(busy32), .err_spurious(err32)
    );

    // ---------------- stub cores: result = block ^ MASK, 10 cycles later ----------------
    logic [3:0]   cnt8 = '0, cnt32 = '0;
    logic         done8_r = 1'b0, done32_r = 1'b0;
    logic [127:0] blk8_r = '0, blk32_r = '0, res8_r = '0, res32_r = '0;
    int           starts8 = 0, starts32 = 0;

    assign core_done8    = done8_r | inj8;
    assign core_result8  = res8_r;
    assign core_done32   = done32_r;
    assign core_result32 = res32_r;

    always @(posedge clk) begin
        done8_r <= 1'b0;
        if (core_start8) starts8 <= starts8 + 1;
        if (rst) cnt8 <= '0;
        else if (core_start8) begin
            cnt8   <= 4'd10;
            blk8_r <= core_block8;
        end else if (cnt8 != 0) begin
            cnt8 <= cnt8 - 1'b1;
            if (cnt8 == 4'd1) begin
                done8_r <= 1'b1;
                res8_r  <= blk8_r ^ MASK;
            end
        end
    end

    always @(posedge clk) begin
        done32_r <= 1'b0;
        if (core_start32) starts32 <= starts32 + 1;
        if (rst) cnt32 <= '0;
        else if (core_start32) begin
            cnt32   <= 4'd10;
            blk32_r <= core_block32;
        end else if (cnt32 != 0) begin
            cnt32 <= cnt32 - 1'b1;
            if (cnt32 == 4'd1) begin
                done32_r <= 1'b1;
                res32_r  <= blk32_r ^ MASK;
            end
        end
    end

    // ---------------- driver tasks (entered and left at posedge + 1) ----------------
    task automatic send8(input logic [7:0] b, output int waits);
        waits    = 0;
        s_valid8 = 1'b1;
        s_data8  = b;
        @(negedge clk);
        while (!s_ready8 && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!s_ready8) begin
            total++; bad++;
            $display("FAIL send8_timeout got=s_ready0 want=s_ready1");
        end
        @(posedge clk); #1;
        s_valid8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] b);
        int waits = 0;
        s_valid32 = 1'b1;
        s_data32  = b;
        @(negedge clk);
        while (!s_ready32 && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!s_ready32) begin
            total++; bad++;
            $display("FAIL send32_timeout got=s_ready0 want=s_ready1");
        end
        @(posedge clk); #1;
        s_valid32 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst  = 1'b1;
        inj8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        inj8 = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        total++; if (s_ready8 !== 1'b1) begin bad++; $display("FAIL reset_s_ready8 got=%b want=1", s_ready8); end
        total++; if (m_valid8 !== 1'b0) begin bad++; $display("FAIL reset_m_valid8 got=%b want=0", m_valid8); end
        total++; if (core_start8 !== 1'b0) begin bad++; $display("FAIL reset_core_start8 got=%b want=0", core_start8); end
        total++; if (m_last8 !== 1'b0) begin bad++; $display("FAIL reset_m_last8 got=%b want=0", m_last8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b want=0", busy8); end
        total++; if (err8 !== 1'b0) begin bad++; $display("FAIL reset_err8_done_in_rst got=%b want=0", err8); end
        total++; if (m_data8 !== 8'h00) begin bad++; $display("FAIL reset_m_data8 got=%h want=00", m_data8); end
        total++; if (core_block8 !== 128'h0) begin bad++; $display("FAIL reset_core_block8 got=%h want=0", core_block8); end
        total++; if (s_ready32 !== 1'b1) begin bad++; $display("FAIL reset_s_ready32 got=%b want=1", s_ready32); end
        total++; if (m_valid32 !== 1'b0) begin bad++; $display("FAIL reset_m_valid32 got=%b want=0", m_valid32); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic8;
        int w, n, c, s0;
        logic [31:0] e;
        s0       = starts8;
        m_ready8 = 1'b1;
        for (int k = 0; k < 16; k++) send8(in8[k], w);
        @(negedge clk);
        total++; if (core_start8 !== 1'b1) begin bad++; $display("FAIL basic8_start_latency got=%b want=1", core_start8); end
        total++; if (core_block8 !== BLK1) begin bad++; $display("FAIL basic8_core_block got=%h want=%h", core_block8, BLK1); end
        for (int k = 0; k < 16; k++) exp_q.push_back({24'h0, out8[k]});
        c = 0;
        while (!core_done8 && c < 50) begin @(negedge clk); c++; end
        total++; if (core_done8 !== 1'b1) begin bad++; $display("FAIL basic8_done_timeout got=%b want=1", core_done8); end
        total++; if (m_valid8 !== 1'b0) begin bad++; $display("FAIL basic8_m_valid_at_done got=%b want=0", m_valid8); end
        @(negedge clk);
        total++; if (m_valid8 !== 1'b1) begin bad++; $display("FAIL basic8_m_valid_latency got=%b want=1", m_valid8); end
        n = 0; c = 0;
        while (n < 16 && c < 100) begin
            if (m_valid8) begin
                e = exp_q.pop_front();
                total++; if (m_data8 !== e[7:0]) begin bad++; $display("FAIL basic8_data[%0d] got=%h want=%h", n, m_data8, e[7:0]); end
                total++; if (m_last8 !== (n == 15)) begin bad++; $display("FAIL basic8_last[%0d] got=%b want=%b", n, m_last8, (n == 15)); end
                n++;
            end
            @(negedge clk); c++;
        end
        total++; if (n != 16) begin bad++; $display("FAIL basic8_beat_count got=%0d want=16", n); end
        total++; if (m_valid8 !== 1'b0) begin bad++; $display("FAIL basic8_m_valid_after got=%b want=0", m_valid8); end
        total++; if (starts8 - s0 != 1) begin bad++; $display("FAIL basic8_start_count got=%0d want=1", starts8 - s0); end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_w32;
        int n, c, s0;
        s0        = starts32;
        m_ready32 = 1'b1;
        for (int k = 0; k < 4; k++) send32(in32[k]);
        @(negedge clk);
        total++; if (core_start32 !== 1'b1) begin bad++; $display("FAIL w32_start_after_4 got=%b want=1", core_start32); end
        total++; if (core_block32 !== BLK1) begin bad++; $display("FAIL w32_core_block got=%h want=%h", core_block32, BLK1); end
        n = 0; c = 0;
        while (n < 4 && c < 100) begin
            @(negedge clk); c++;
            if (m_valid32) begin
                total++; if (m_data32 !== out32[n]) begin bad++; $display("FAIL w32_data[%0d] got=%h want=%h", n, m_data32, out32[n]); end
                total++; if (m_last32 !== (n == 3)) begin bad++; $display("FAIL w32_last[%0d] got=%b want=%b", n, m_last32, (n == 3)); end
                n++;
            end
        end
        total++; if (n != 4) begin bad++; $display("FAIL w32_beat_count got=%0d want=4", n); end
        total++; if (starts32 - s0 != 1) begin bad++; $display("FAIL w32_start_count got=%0d want=1", starts32 - s0); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int w, n, c, s0, stall;
        s0       = starts8;
        m_ready8 = 1'b0;
        for (int k = 0; k < 16; k++) send8(in8[k], w);
        for (int k = 0; k < 16; k++) send8(~in8[k], w);
        @(negedge clk);
        total++; if (s_ready8 !== 1'b0) begin bad++; $display("FAIL bp_s_ready_held got=%b want=0", s_ready8); end
        total++; if (starts8 - s0 != 1) begin bad++; $display("FAIL bp_start_count got=%0d want=1", starts8 - s0); end
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b want=1", busy8); end
        n = 0; c = 0; stall = 0;
        while (n < 16 && c < 200) begin
            total++; if (core_start8 !== 1'b0) begin bad++; $display("FAIL bp_early_start beat=%0d got=1 want=0", n); end
            if (m_valid8 && m_ready8) begin
                total++; if (m_data8 !== out8[n]) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", n, m_data8, out8[n]); end
                n++;
            end else begin
                total++; if (m_valid8 !== 1'b1 || m_data8 !== out8[n]) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/%h", n, m_valid8, m_data8, out8[n]); end
            end
            @(posedge clk); #1;
            if (n == 3 && stall < 5) begin m_ready8 = 1'b0; stall++; end
            else m_ready8 = 1'b1;
            @(negedge clk); c++;
        end
        total++; if (stall != 5) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=5", stall); end
        total++; if (core_start8 !== 1'b1) begin bad++; $display("FAIL bp_start_after_last got=%b want=1", core_start8); end
        total++; if (core_block8 !== ~BLK1) begin bad++; $display("FAIL bp_block2 got=%h want=%h", core_block8, ~BLK1); end
        c = 0;
        while (!core_done8 && c < 60) begin @(negedge clk); c++; end
        total++; if (core_done8 !== 1'b1) begin bad++; $display("FAIL bp_done2_timeout got=%b want=1", core_done8); end
        n = 0; c = 0;
        while (n < 16 && c < 100) begin
            @(negedge clk); c++;
            if (m_valid8) begin
                total++; if (m_data8 !== ~out8[n]) begin bad++; $display("FAIL bp_data2[%0d] got=%h want=%h", n, m_data8, ~out8[n]); end
                n++;
            end
        end
        total++; if (n != 16) begin bad++; $display("FAIL bp_beat_count2 got=%0d want=16", n); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int s0, waits_tot, n, c;
        logic [7:0] e;
        s0        = starts8;
        waits_tot = 0;
        m_ready8  = 1'b1;
        fork
            begin
                int w;
                for (int k = 0; k < 32; k++) begin
                    if (k < 16) send8(in8[k], w);
                    else send8(~in8[k-16], w);
                    waits_tot += w;
                end
            end
            begin
                n = 0; c = 0;
                while (n < 32 && c < 300) begin
                    @(negedge clk); c++;
                    if (m_valid8) begin
                        if (n < 16) e = out8[n];
                        else e = ~out8[n-16];
                        total++; if (m_data8 !== e) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", n, m_data8, e); end
                        total++; if (m_last8 !== (n % 16 == 15)) begin bad++; $display("FAIL b2b_last[%0d] got=%b want=%b", n, m_last8, (n % 16 == 15)); end
                        n++;
                    end
                end
                total++; if (n != 32) begin bad++; $display("FAIL b2b_beat_count got=%0d want=32", n); end
            end
        join
        total++; if (waits_tot != 0) begin bad++; $display("FAIL b2b_input_bubbles got=%0d want=0", waits_tot); end
        total++; if (starts8 - s0 != 2) begin bad++; $display("FAIL b2b_start_count got=%0d want=2", starts8 - s0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int w, n, c, s0;
        m_ready8 = 1'b1;
        for (int k = 0; k < 6; k++) send8(8'ha0 + 8'(k), w);
        s_valid8 = 1'b1;
        s_data8  = 8'hee;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        s_valid8 = 1'b0;
        @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy8); end
        total++; if (s_ready8 !== 1'b1) begin bad++; $display("FAIL rmid_s_ready got=%b want=1", s_ready8); end
        @(posedge clk); #1;
        s0 = starts8;
        for (int k = 0; k < 16; k++) send8(in8[k], w);
        @(negedge clk);
        total++; if (core_start8 !== 1'b1) begin bad++; $display("FAIL rmid_start got=%b want=1", core_start8); end
        total++; if (core_block8 !== BLK1) begin bad++; $display("FAIL rmid_block got=%h want=%h", core_block8, BLK1); end
        n = 0; c = 0;
        while (n < 16 && c < 100) begin
            @(negedge clk); c++;
            if (m_valid8) begin
                total++; if (m_data8 !== out8[n]) begin bad++; $display("FAIL rmid_data[%0d] got=%h want=%h", n, m_data8, out8[n]); end
                n++;
            end
        end
        total++; if (starts8 - s0 != 1) begin bad++; $display("FAIL rmid_start_count got=%0d want=1", starts8 - s0); end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious;
        logic ok;
        @(negedge clk);
        total++; if (err8 !== 1'b0) begin bad++; $display("FAIL spur_err_before got=%b want=0", err8); end
        @(posedge clk); #1;
        inj8 = 1'b1;
        @(posedge clk); #1;
        inj8 = 1'b0;
        @(negedge clk);
        total++; if (err8 !== 1'b1) begin bad++; $display("FAIL spur_err_set got=%b want=1", err8); end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err8 !== 1'b1 || m_valid8 !== 1'b0) ok = 1'b0;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL spur_sticky_no_output got=%b want=1", ok); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (err8 !== 1'b0) begin bad++; $display("FAIL spur_err_cleared got=%b want=0", err8); end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(posedge clk); #1;
        test_reset;
        test_basic8;
        test_w32;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_spurious;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
